// File: rtl/cplx_sum_tree4_pkg.sv
// Shared widths for the adder tree and the downstream normaliser.
// Both blocks derive their sum and leading-zero-count widths from these helpers.
package cplx_sum_tree4_pkg;

  localparam int unsigned SigWidth  = 6;
  localparam int unsigned LowExpand = 2;
  localparam int unsigned DefWidth  = SigWidth + 4 + LowExpand;

  // Full-precision sum of four lanes: two extra bits of growth.
  function automatic int unsigned sum_width(input int unsigned width);
    return width + 2;
  endfunction

  // Count range 0..width+1 for a width+1 bit magnitude.
  function automatic int unsigned lzc_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/cplx_sum_tree4_lzc_count.sv
// Combinational leading-zero counter; an all-zero input yields N.
// Shared with the normaliser.
module cplx_sum_tree4_lzc_count #(
  parameter int unsigned N    = 13,
  parameter int unsigned CntW = $clog2(N + 1)
) (
  input  logic [N-1:0]    value,
  output logic [CntW-1:0] count
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count = CntW'(N);
    for (int i = 0; i < int'(N); i++) begin
      if (value[i]) begin
        count = CntW'(int'(N) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/cplx_sum_tree4.sv
// Three-stage 4-lane signed adder tree producing sign-magnitude sum and leading-zero count.
// A single advance signal stalls every stage together.
module cplx_sum_tree4
  import cplx_sum_tree4_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LZC_W = lzc_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [WIDTH:0]     out_mag,
  output logic [LZC_W-1:0]   out_lzc,
  output logic               out_zero
);

  localparam int unsigned SumW = sum_width(WIDTH);
  localparam logic [WIDTH-1:0] MinCode = {1'b1, {(WIDTH - 1){1'b0}}};

  logic              adv;
  logic [WIDTH-1:0]  lane0, lane1, lane2, lane3;
  logic [WIDTH:0]    p0_d, p1_d, p0_q, p1_q;
  logic [SumW-1:0]   sum_d, sum_q;
  logic              s1_valid_q, s2_valid_q, out_valid_q;
  logic              sign_d, zero_d;
  logic [WIDTH:0]    mag_d;
  logic [LZC_W-1:0]  lzc_d;
  logic              sign_q, zero_q;
  logic [WIDTH:0]    mag_q;
  logic [LZC_W-1:0]  lzc_q;

  assign adv      = out_ready | ~out_valid_q;
  assign in_ready = adv;

  assign lane0 = in_data[0*WIDTH +: WIDTH];
  assign lane1 = in_data[1*WIDTH +: WIDTH];
  assign lane2 = in_data[2*WIDTH +: WIDTH];
  assign lane3 = in_data[3*WIDTH +: WIDTH];

  always_comb begin
    p0_d  = {lane0[WIDTH-1], lane0} + {lane1[WIDTH-1], lane1};
    p1_d  = {lane2[WIDTH-1], lane2} + {lane3[WIDTH-1], lane3};
    sum_d = {p0_q[WIDTH], p0_q} + {p1_q[WIDTH], p1_q};
  end

  // Low bits of the negation depend only on low bits, so the top sum bit is never needed.
  always_comb begin
    sign_d = sum_q[SumW-1];
    zero_d = (sum_q == '0);
    mag_d  = sum_q[SumW-1] ? (~sum_q[WIDTH:0] + 1'b1) : sum_q[WIDTH:0];
  end

  cplx_sum_tree4_lzc_count #(
    .N    (WIDTH + 1),
    .CntW (LZC_W)
  ) u_lzc (
    .value (mag_d),
    .count (lzc_d)
  );

  // Data registers load only with a valid beat so idle in_data cannot disturb held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      p0_q        <= '0;
      p1_q        <= '0;
      sum_q       <= '0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      lzc_q       <= '0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (in_valid) begin
        p0_q <= p0_d;
        p1_q <= p1_d;
      end
      if (s1_valid_q) begin
        sum_q <= sum_d;
      end
      if (s2_valid_q) begin
        sign_q <= sign_d;
        mag_q  <= mag_d;
        lzc_q  <= lzc_d;
        zero_q <= zero_d;
      end
    end
  end

  // All-most-negative lanes would wrap the magnitude; upstream must never send it.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && adv) begin
      assert (!(lane0 == MinCode && lane1 == MinCode && lane2 == MinCode && lane3 == MinCode));
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = sign_q;
  assign out_mag   = mag_q;
  assign out_lzc   = lzc_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_cplx_sum_tree4.sv
// Directed and random checks of cplx_sum_tree4 at WIDTH=12.
module tb_cplx_sum_tree4;

  localparam int NRand = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [12:0] out_mag;
  logic [3:0]  out_lzc;
  logic        out_zero;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic        held;
  logic [18:0] held_out;
  logic [18:0] exp_q[$];
  int          rcv;
  int          sent;
  logic [47:0] beats [5];

  always #5 clk = ~clk;

  cplx_sum_tree4 #(
    .WIDTH (12),
    .LZC_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_lzc   (out_lzc),
    .out_zero  (out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: integer sum, absolute value, top-down zero scan. Packed {sign, mag, lzc, zero}.
  function automatic logic [18:0] model(input logic [47:0] d);
    int          s;
    int          a;
    int          lz;
    logic [12:0] m;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      logic [11:0] l;
      l = d[12*k +: 12];
      s = s + int'($signed(l));
    end
    a  = (s < 0) ? -s : s;
    m  = a[12:0];
    lz = 13;
    for (int b = 12; b >= 0; b--) begin
      if (m[b]) begin
        lz = 12 - b;
        break;
      end
    end
    return {(s < 0), m, lz[3:0], (s == 0)};
  endfunction

  function automatic logic [11:0] rlane();
    logic [11:0] v;
    do v = 12'($urandom_range(0, 4095)); while (v == 12'h800);
    return v;
  endfunction

  function automatic logic [47:0] rbeat();
    return {rlane(), rlane(), rlane(), rlane()};
  endfunction

  // Called at the negedge: stall/stability checks, scoreboard pop and push.
  task automatic observe(input string tag);
    logic [18:0] o;
    o = {out_sign, out_mag, out_lzc, out_zero};
    if (held) begin
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_data"}, 32'(o), 32'(held_out));
    end
    if (out_valid && !out_ready) chk({tag, "_in_ready_stall"}, 32'(in_ready), 32'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk({tag, "_extra_result"}, 32'(exp_q.size()), 32'd1);
      else begin
        chk({tag, "_result"}, 32'(o), 32'(exp_q.pop_front()));
        rcv++;
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(in_data));
    held     = out_valid && !out_ready;
    held_out = o;
  endtask

  // Entered and left at posedge+1 with out_ready high.
  task automatic run_vec(input string tag, input logic [11:0] l0, l1, l2, l3,
                         input logic esign, input logic [12:0] emag, input logic [3:0] elzc,
                         input logic ezero);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {l3, l2, l1, l0};
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rbeat();
    lat = 1;
    forever begin
      @(negedge clk);
      if (out_valid || lat >= 8) break;
      @(posedge clk); #1;
      in_data = rbeat();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_sign"}, 32'(out_sign), 32'(esign));
    chk({tag, "_mag"}, 32'(out_mag), 32'(emag));
    chk({tag, "_lzc"}, 32'(out_lzc), 32'(elzc));
    chk({tag, "_zero"}, 32'(out_zero), 32'(ezero));
    @(posedge clk); #1;
  endtask

  initial begin
    int ghosts;
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    held      = 1'b0;
    held_out  = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sign", 32'(out_sign), 32'd0);
    chk("reset_mag", 32'(out_mag), 32'd0);
    chk("reset_lzc", 32'(out_lzc), 32'd0);
    chk("reset_zero", 32'(out_zero), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_vec("mixed", 12'h005, 12'h003, 12'hFFE, 12'hFFF, 1'b0, 13'h0005, 4'd10, 1'b0);
    run_vec("pos_ext", 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 1'b0, 13'h1FFC, 4'd0, 1'b0);
    run_vec("neg_ext", 12'h801, 12'h801, 12'h801, 12'h801, 1'b1, 13'h1FFC, 4'd0, 1'b0);
    run_vec("zero", 12'h005, 12'hFFB, 12'h003, 12'hFFD, 1'b0, 13'h0000, 4'd13, 1'b0 | 1'b1);
    run_vec("minus1", 12'hFFF, 12'h000, 12'h000, 12'h000, 1'b1, 13'h0001, 4'd12, 1'b0);
    run_vec("pow2", 12'h400, 12'h400, 12'h000, 12'h000, 1'b0, 13'h0800, 4'd1, 1'b0);

    // Five back-to-back beats with out_ready low on cycles 4-6.
    beats[0] = {12'h004, 12'h003, 12'h002, 12'h001};
    beats[1] = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    beats[2] = {12'h000, 12'h000, 12'h000, 12'h100};
    beats[3] = {12'h000, 12'h000, 12'h001, 12'h7FF};
    beats[4] = {12'h000, 12'h000, 12'h000, 12'h801};
    exp_q.delete();
    held = 1'b0;
    sent = 0;
    rcv  = 0;
    for (int c = 1; c <= 14; c++) begin
      in_valid  = (sent < 5);
      in_data   = (sent < 5) ? beats[sent] : rbeat();
      out_ready = !(c >= 4 && c <= 6);
      @(negedge clk);
      observe("stream");
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    chk("stream_count", 32'(rcv), 32'd5);
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);

    // Reset with two beats in the pipe and a third being offered.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {12'h001, 12'h001, 12'h001, 12'h001};
    @(posedge clk); #1;
    in_data = {12'h002, 12'h002, 12'h002, 12'h002};
    @(posedge clk); #1;
    in_data = {12'h003, 12'h003, 12'h003, 12'h003};
    rst     = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sign", 32'(out_sign), 32'd0);
    chk("midrst_mag", 32'(out_mag), 32'd0);
    chk("midrst_lzc", 32'(out_lzc), 32'd0);
    chk("midrst_zero", 32'(out_zero), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    ghosts = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      in_data = rbeat();
      @(negedge clk);
      if (out_valid) ghosts++;
    end
    chk("midrst_ghosts", 32'(ghosts), 32'd0);
    @(posedge clk); #1;
    run_vec("post_rst", 12'h010, 12'hFF0, 12'h020, 12'h001, 1'b0, 13'h0021, 4'd7, 1'b0);

    // Random legal traffic with random back-pressure.
    exp_q.delete();
    held = 1'b0;
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while ((sent < NRand || exp_q.size() != 0) && cyc < 60000) begin
      in_valid  = (sent < NRand) && ($urandom_range(0, 9) < 8);
      in_data   = rbeat();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      observe("rand");
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_count", 32'(rcv), 32'(NRand));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
